// File: rtl/hilo_muldiv.sv
// Multicycle signed multiply (radix-2 Booth) / restoring divide feeding the HI/LO registers.
// Optional macro MULDIV_UNSIGNED_EN adds is_unsigned for multu/divu.
module hilo_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
`ifdef MULDIV_UNSIGNED_EN
   input  logic             is_unsigned,
`endif
   input  logic [WIDTH-1:0] input_a,
   input  logic [WIDTH-1:0] input_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

   state_t state_q, state_d;
   logic              div0_d;
   logic [CW-1:0]     cnt_q;
   logic              last;

   logic signed [2*WIDTH:0] acc_q, acc_d;
   logic [WIDTH-1:0]        mcand_q;
   logic signed [WIDTH:0]   a_ext, m_ext, sum;
   logic [WIDTH-1:0]        prod_hi;

   logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_d, quo_d;
   logic [WIDTH:0]   shifted;
   logic             ge;
   logic             negq_q, negr_q;

   logic uns_in, a_neg, b_neg;

`ifdef MULDIV_UNSIGNED_EN
   logic             uns_q;
   logic [WIDTH-1:0] b_q;
   assign uns_in = is_unsigned;
`else
   assign uns_in = 1'b0;
`endif

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
      return neg ? (~mag + 1'b1) : mag;
   endfunction

   assign a_neg = ~uns_in & input_a[WIDTH-1];
   assign b_neg = ~uns_in & input_b[WIDTH-1];
   assign last  = (cnt_q == CW'(WIDTH-1));

   always_comb begin
      state_d = state_q;
      div0_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_mult) begin
               state_d = S_MULT;
            end else if (start_div) begin
               if (input_b == '0) begin
                  state_d = S_DONE;
                  div0_d  = 1'b1;
               end else begin
                  state_d = S_DIV;
               end
            end
         end
         S_MULT, S_DIV: if (last) state_d = S_DONE;
         S_DONE:        state_d = S_IDLE;
         default:       state_d = S_IDLE;
      endcase
   end

   // Booth step: the add is one bit wider so a most-negative multiplicand cannot overflow
   always_comb begin
      a_ext = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
      m_ext = {mcand_q[WIDTH-1], mcand_q};
      case (acc_q[1:0])
         2'b01:   sum = a_ext + m_ext;
         2'b10:   sum = a_ext - m_ext;
         default: sum = a_ext;
      endcase
      acc_d = {sum, acc_q[WIDTH:1]};
`ifdef MULDIV_UNSIGNED_EN
      // Unsigned product = signed product plus cross terms for operands with MSB set
      prod_hi = acc_d[2*WIDTH:WIDTH+1]
              + ((uns_q & mcand_q[WIDTH-1]) ? b_q : '0)
              + ((uns_q & b_q[WIDTH-1]) ? mcand_q : '0);
`else
      prod_hi = acc_d[2*WIDTH:WIDTH+1];
`endif
   end

   // Restoring divide step on magnitudes; quotient shifts in where the dividend shifts out
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      ge      = (shifted >= {1'b0, dvs_q});
      rem_d   = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
      quo_d   = {quo_q[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
`ifdef MULDIV_UNSIGNED_EN
         uns_q    <= 1'b0;
         b_q      <= '0;
`endif
      end else begin
         state_q  <= state_d;
         busy     <= (state_d == S_MULT) || (state_d == S_DIV);
         done     <= (state_d == S_DONE);
         div_zero <= div0_d;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (start_mult) begin
                  acc_q   <= {{WIDTH{1'b0}}, input_b, 1'b0};
                  mcand_q <= input_a;
`ifdef MULDIV_UNSIGNED_EN
                  uns_q   <= is_unsigned;
                  b_q     <= input_b;
`endif
               end else if (start_div) begin
                  rem_q  <= '0;
                  quo_q  <= apply_sign(input_a, a_neg);
                  dvs_q  <= apply_sign(input_b, b_neg);
                  negq_q <= a_neg ^ b_neg;
                  negr_q <= a_neg;
               end
            end
            S_MULT: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (last) begin
                  hi_out <= prod_hi;
                  lo_out <= acc_d[WIDTH:1];
               end
            end
            S_DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 1'b1;
               if (last) begin
                  lo_out <= apply_sign(quo_d, negq_q);
                  hi_out <= apply_sign(rem_d, negr_q);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized self-checking bench for hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_mult = 1'b0;
   logic        start_div = 1'b0;
   logic        is_unsigned = 1'b0;
   logic [31:0] input_a = '0;
   logic [31:0] input_b = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi_out, lo_out;

   int checks = 0;
   int failures = 0;
   logic [31:0] mdl_hi = '0;
   logic [31:0] mdl_lo = '0;

   always #5 clk = ~clk;

   hilo_muldiv #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
`ifdef MULDIV_UNSIGNED_EN
      .is_unsigned(is_unsigned),
`endif
      .input_a    (input_a),
      .input_b    (input_b),
      .busy       (busy),
      .done       (done),
      .div_zero   (div_zero),
      .hi_out     (hi_out),
      .lo_out     (lo_out)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // HI/LO after an operation, from plain 64-bit arithmetic
   task automatic model(input bit mul, input bit uns, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      longint sa, sb, q, r;
      if (mul) begin
         if (uns) p = {32'b0, a} * {32'b0, b};
         else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = sa * sb;
         end
         mdl_hi = p[63:32];
         mdl_lo = p[31:0];
      end else if (b != 0) begin
         if (uns) begin
            mdl_lo = a / b;
            mdl_hi = a % b;
         end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            mdl_lo = q[31:0];
            mdl_hi = r[31:0];
         end
      end
   endtask

   task automatic run_op(input string tag, input bit sm, input bit sd, input logic [31:0] a,
                         input logic [31:0] b, input bit uns, input int inj_k, input int rst_k);
      logic [31:0] prev_hi, prev_lo;
      bit ediv0, dz_seen;
      int dk, nb, ndone, unstable, stray_dz;
      prev_hi = mdl_hi;
      prev_lo = mdl_lo;
      ediv0 = !sm && sd && (b == 0);
      model(sm, uns, a, b);
      @(negedge clk);
      start_mult = sm; start_div = sd; input_a = a; input_b = b; is_unsigned = uns;
      @(negedge clk);
      start_mult = 0; start_div = 0; input_a = $urandom; input_b = $urandom; is_unsigned = $urandom_range(0, 1);
      dk = 0; nb = 0; ndone = 0; unstable = 0; stray_dz = 0; dz_seen = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k == inj_k) begin start_div = 1; input_b = 32'd3; end
         if (k == inj_k + 1) start_div = 0;
         if (k == rst_k) begin
            reset = 0;
            #1;
            chk({tag, ".rst_busy"}, busy, 0);
            chk({tag, ".rst_hi"}, hi_out, 0);
            chk({tag, ".rst_lo"}, lo_out, 0);
            mdl_hi = '0; mdl_lo = '0;
         end
         if (rst_k != 0 && k == rst_k + 1) reset = 1;
         if (done) begin
            ndone++;
            if (dk == 0) begin dk = k; dz_seen = div_zero; end
         end else if (div_zero) stray_dz++;
         if (busy) nb++;
         if (dk == 0 && (rst_k == 0 || k < rst_k) && (hi_out !== prev_hi || lo_out !== prev_lo)) unstable++;
         @(negedge clk);
      end
      if (rst_k == 0) begin
         chk({tag, ".done_cycle"}, dk, ediv0 ? 1 : 33);
         chk({tag, ".done_count"}, ndone, 1);
         chk({tag, ".busy_cycles"}, nb, ediv0 ? 0 : 32);
         chk({tag, ".div_zero"}, dz_seen, ediv0);
         chk({tag, ".stray_dz"}, stray_dz, 0);
         chk({tag, ".stable"}, unstable, 0);
      end else begin
         chk({tag, ".done_after_rst"}, ndone, 0);
         chk({tag, ".stable"}, unstable, 0);
      end
      chk({tag, ".hi"}, hi_out, mdl_hi);
      chk({tag, ".lo"}, lo_out, mdl_lo);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 4))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'($signed($urandom_range(0, 40)) - 20);
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] ra, rb;
      bit rm, rd, ru;
      #3;
      chk("reset.busy", busy, 0);
      chk("reset.done", done, 0);
      chk("reset.div_zero", div_zero, 0);
      chk("reset.hi", hi_out, 0);
      chk("reset.lo", lo_out, 0);
      @(negedge clk);
      reset = 1;

      run_op("t1_mul", 1, 0, 32'd7, 32'hFFFF_FFFD, 0, 0, 0);
      chk("t1.hi_const", hi_out, 32'hFFFF_FFFF);
      chk("t1.lo_const", lo_out, 32'hFFFF_FFEB);
      run_op("t2_mul", 1, 0, 32'h0001_0000, 32'h0001_0000, 0, 0, 0);
      chk("t2.hi_const", hi_out, 32'h1);
      run_op("t2_div", 0, 1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
      chk("t2.div_lo_const", lo_out, 32'hFFFF_FFFD);
      run_op("t3_div0", 0, 1, 32'd5, 32'd0, 0, 0, 0);
      chk("t3.hi_kept", hi_out, 32'hFFFF_FFFF);
      chk("t3.lo_kept", lo_out, 32'hFFFF_FFFD);
      run_op("t4_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      chk("t4.ovf_lo_const", lo_out, 32'h8000_0000);
      run_op("t4_both", 1, 1, 32'd3, 32'd4, 0, 0, 0);
      chk("t4.both_lo_const", lo_out, 32'd12);
      run_op("t5_inj", 1, 0, 32'd3, 32'd5, 0, 10, 0);
      chk("t5.lo_const", lo_out, 32'd15);
      run_op("t5_rst", 1, 0, 32'd3, 32'd5, 0, 0, 10);
      run_op("mn_mn", 1, 0, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
`ifdef MULDIV_UNSIGNED_EN
      run_op("t6_multu", 1, 0, 32'hFFFF_FFFF, 32'd2, 1, 0, 0);
      chk("t6.multu_hi_const", hi_out, 32'd1);
      run_op("t6_divu", 0, 1, 32'hFFFF_FFFF, 32'd2, 1, 0, 0);
      chk("t6.divu_lo_const", lo_out, 32'h7FFF_FFFF);
`endif

      for (int i = 0; i < 40; i++) begin
         ra = pick();
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : pick();
         rm = $urandom_range(0, 1);
         rd = !rm || ($urandom_range(0, 3) == 0);
`ifdef MULDIV_UNSIGNED_EN
         ru = $urandom_range(0, 1);
`else
         ru = 0;
`endif
         run_op($sformatf("rnd%0d", i), rm, rd, ra, rb, ru, 0, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
